cmp_n_fpga: RTL and testbench

CMP_N_FPGA -- requirements
Module: cmp_n_fpga

---
 rtl/cmp_n_fpga.sv | 169 ++++++++++++++++
 tb/tb_cmp_n_fpga.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_n_fpga.sv
// ---------------------------------------------------------------------------
// cmp_n_fpga
//
// Two-operand unsigned comparator for a board with slide switches and two
// push buttons. Each button is synchronised, debounced and edge-detected; a
// debounced press captures the switch value into operand A or B. The
// comparison flags and a mode-selected result are registered every cycle.
//
// Parameters
//   WIDTH     operand width in bits (1..32)
//   DEBOUNCE  consecutive stable synchronised cycles before a button change
//             is accepted (1..2^20)
//
// Ports
//   clock   in   1      system clock, all state updates on the rising edge
//   reset   in   1      asynchronous, active-high reset
//   sw      in   WIDTH  operand value from the switches
//   btn_a   in   1      raw button, asynchronous; loads operand A
//   btn_b   in   1      raw button, asynchronous; loads operand B
//   mode    in   2      result select: 00 eq, 01 ne, 10 A<B, 11 A>B
//   opa     out  WIDTH  registered operand A
//   opb     out  WIDTH  registered operand B
//   eq      out  1      registered A==B
//   lt      out  1      registered A<B
//   gt      out  1      registered A>B
//   result  out  1      registered mode-selected flag
//   valid   out  1      both operands loaded since reset
// ---------------------------------------------------------------------------
module cmp_n_fpga #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             result,
    output logic             valid
);

    localparam int             CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

    // Index 0 is button A, index 1 is button B throughout.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         db_q,    db_d;
    logic [1:0]         load_q,  load_d;
    logic [1:0][CW-1:0] cnt_q,   cnt_d;

    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               a_loaded_q, a_loaded_d;
    logic               b_loaded_q, b_loaded_d;
    logic               valid_q, valid_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;
    logic               result_q, result_d;

    // Mode-selected comparison of the two operands (unsigned).
    function automatic logic mode_select(input logic [1:0]       m,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
        logic r;
        case (m)
            2'b00:   r = (a == b);
            2'b01:   r = (a != b);
            2'b10:   r = (a <  b);
            default: r = (a >  b);
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Synchroniser and debounce next-state
    // -----------------------------------------------------------------------
    always_comb begin
        sync1_d = {btn_b, btn_a};
        sync2_d = sync1_q;
        db_d    = db_q;
        load_d  = 2'b00;
        cnt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                // The change has been stable for DEBOUNCE cycles when the
                // counter reaches DEBOUNCE-1 on this edge.
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]   = sync2_q[i];
                    // Registered pulse only on a rising debounced level, so
                    // the operand captures one edge after db rises.
                    load_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Operand capture, flags and result next-state
    // -----------------------------------------------------------------------
    always_comb begin
        opa_d      = load_q[0] ? sw : opa_q;
        opb_d      = load_q[1] ? sw : opb_q;
        a_loaded_d = a_loaded_q | load_q[0];
        b_loaded_d = b_loaded_q | load_q[1];
        valid_d    = a_loaded_q & b_loaded_q;
        // Flags track the operands currently held, independent of valid.
        eq_d       = (opa_q == opb_q);
        lt_d       = (opa_q <  opb_q);
        gt_d       = (opa_q >  opb_q);
        result_d   = mode_select(mode, opa_q, opb_q);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            db_q       <= 2'b00;
            load_q     <= 2'b00;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            a_loaded_q <= 1'b0;
            b_loaded_q <= 1'b0;
            valid_q    <= 1'b0;
            // Operands reset to equal values, so eq is the consistent flag.
            eq_q       <= 1'b1;
            lt_q       <= 1'b0;
            gt_q       <= 1'b0;
            result_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            load_q     <= load_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            a_loaded_q <= a_loaded_d;
            b_loaded_q <= b_loaded_d;
            valid_q    <= valid_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            gt_q       <= gt_d;
            result_q   <= result_d;
        end
    end

    assign opa    = opa_q;
    assign opb    = opb_q;
    assign eq     = eq_q;
    assign lt     = lt_q;
    assign gt     = gt_q;
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_cmp_n_fpga.sv
// ---------------------------------------------------------------------------
// tb_cmp_n_fpga
//
// Directed bench for cmp_n_fpga with WIDTH=8, DEBOUNCE=4. Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_cmp_n_fpga;

    localparam int WIDTH    = 8;
    localparam int DEBOUNCE = 4;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] sw;
    logic             btn_a;
    logic             btn_b;
    logic [1:0]       mode;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             eq;
    logic             lt;
    logic             gt;
    logic             result;
    logic             valid;

    int n_cmp = 0;
    int n_err = 0;

    cmp_n_fpga #(
        .WIDTH    (WIDTH),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .sw     (sw),
        .btn_a  (btn_a),
        .btn_b  (btn_b),
        .mode   (mode),
        .opa    (opa),
        .opb    (opb),
        .eq     (eq),
        .lt     (lt),
        .gt     (gt),
        .result (result),
        .valid  (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Press long enough to load (capture at the 7th edge), then release long
    // enough for the debounced level to fall again.
    task automatic load_a(input logic [WIDTH-1:0] v);
        sw = v;
        btn_a = 1'b1;
        tick(8);
        btn_a = 1'b0;
        tick(8);
    endtask

    task automatic load_b(input logic [WIDTH-1:0] v);
        sw = v;
        btn_b = 1'b1;
        tick(8);
        btn_b = 1'b0;
        tick(8);
    endtask

    initial begin
        reset = 1'b1;
        sw    = '0;
        btn_a = 1'b0;
        btn_b = 1'b0;
        mode  = 2'b00;
        tick(2);

        // Reset state
        chk("rst_opa",    opa,    0);
        chk("rst_opb",    opb,    0);
        chk("rst_eq",     eq,     1);
        chk("rst_lt",     lt,     0);
        chk("rst_gt",     gt,     0);
        chk("rst_result", result, 0);
        chk("rst_valid",  valid,  0);
        reset = 1'b0;

        // Scenario 1: A=5 then B=5, exact load/flag/valid latency
        sw    = 8'd5;
        btn_a = 1'b1;
        tick(6);
        chk("s1_opa_before_edge7", opa, 0);
        tick(1);
        chk("s1_opa_edge7", opa, 5);
        tick(3);
        btn_a = 1'b0;
        tick(8);
        chk("s1_gt_a_only",    gt,    1);
        chk("s1_eq_a_only",    eq,    0);
        chk("s1_valid_a_only", valid, 0);
        btn_b = 1'b1;
        tick(7);
        chk("s1_opb_edge7",  opb,   5);
        chk("s1_valid_edge7", valid, 0);
        tick(1);
        chk("s1_valid_edge8",  valid,  1);
        chk("s1_eq_edge8",     eq,     1);
        chk("s1_result_edge8", result, 1);
        chk("s1_onehot", 32'(eq) + 32'(lt) + 32'(gt), 1);
        btn_b = 1'b0;
        tick(8);

        // Scenario 2: 3-cycle glitch ignored, 4-cycle press loads
        do_reset();
        sw    = 8'd6;
        btn_a = 1'b1;
        tick(3);
        btn_a = 1'b0;
        tick(10);
        chk("s2_glitch_opa", opa, 0);
        sw    = 8'd7;
        btn_a = 1'b1;
        tick(4);
        btn_a = 1'b0;
        tick(2);
        chk("s2_press4_before", opa, 0);
        tick(1);
        chk("s2_press4_load", opa, 7);
        tick(8);

        // Scenario 3: A=3, B=12, mode sweep with one-cycle result latency
        load_a(8'd3);
        load_b(8'd12);
        mode = 2'b00;
        tick(1);
        chk("s3_m00_result", result, 0);
        chk("s3_lt",         lt,     1);
        chk("s3_gt",         gt,     0);
        chk("s3_eq",         eq,     0);
        mode = 2'b01;
        chk("s3_m01_not_yet", result, 0);
        tick(1);
        chk("s3_m01_result", result, 1);
        mode = 2'b10;
        tick(1);
        chk("s3_m10_result", result, 1);
        mode = 2'b11;
        chk("s3_m11_not_yet", result, 1);
        tick(1);
        chk("s3_m11_result", result, 0);

        // Scenario 4: simultaneous press captures the same value
        do_reset();
        sw    = 8'd9;
        btn_a = 1'b1;
        btn_b = 1'b1;
        tick(7);
        chk("s4_opa",         opa,   9);
        chk("s4_opb",         opb,   9);
        chk("s4_valid_early", valid, 0);
        tick(1);
        chk("s4_valid", valid, 1);
        chk("s4_eq",    eq,    1);
        btn_a = 1'b0;
        btn_b = 1'b0;
        tick(8);

        // Scenario 5: full-range unsigned compare and held-button single load
        do_reset();
        load_a(8'd255);
        load_b(8'd0);
        mode = 2'b11;
        tick(1);
        chk("s5_gt",     gt,     1);
        chk("s5_lt",     lt,     0);
        chk("s5_result", result, 1);
        chk("s5_valid",  valid,  1);
        sw    = 8'h11;
        btn_a = 1'b1;
        tick(8);
        for (int i = 0; i < 92; i++) begin
            sw = 8'(8'h20 + i * 7);
            tick(1);
        end
        chk("s5_held_single_load", opa, 32'h11);
        sw    = 8'h77;
        btn_a = 1'b0;
        tick(10);
        chk("s5_release_no_load", opa, 32'h11);
        sw = 8'h33;
        tick(3);
        chk("s5_sw_no_press", opa, 32'h11);
        chk("s5_gt_after",    gt,  1);

        // Scenario 6: asynchronous reset mid-debounce, then fresh debounce
        sw    = 8'd4;
        btn_a = 1'b1;
        tick(4);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_async_opa",    opa,    0);
        chk("s6_async_opb",    opb,    0);
        chk("s6_async_valid",  valid,  0);
        chk("s6_async_eq",     eq,     1);
        chk("s6_async_gt",     gt,     0);
        chk("s6_async_result", result, 0);
        tick(1);
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            tick(1);
            chk("s6_rst_result_mode", result, 0);
        end
        reset = 1'b0;
        tick(6);
        chk("s6_before_load", opa, 0);
        tick(1);
        chk("s6_load_d_plus_3", opa, 4);
        btn_a = 1'b0;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
